// File: rtl/mine_placer.sv
// Minesweeper board generator: rejection-samples MINES distinct mines from an
// LFSR byte stream, avoiding the first-clicked cell, then scans adjacency counts.
module mine_placer #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int MINES = 10,
    localparam int CELLS = ROWS * COLS,
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] safe_cell,
    input  logic [7:0]       rand_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic             rd_mine,
    output logic [3:0]       rd_count,
    output logic             busy,
    output logic             done,
    output logic [7:0]       mines_placed
);

    // Storage is padded to a power of two so any candidate index is in range;
    // padded cells are never written and therefore always read as zero.
    localparam int MAP = 1 << IDX_W;

    typedef enum logic [2:0] {IDLE, CLEAR, DRAW, COUNT, DONE} state_t;

    state_t           state;
    logic [MAP-1:0]   mine;
    logic [3:0]       cnt [MAP];
    logic [IDX_W-1:0] safe;
    logic [IDX_W-1:0] p;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;

    logic [IDX_W-1:0] cand;
    logic             accept;
    logic             last_mine;
    logic [3:0]       nbr;
    int               nr;
    int               nc;
    logic [IDX_W-1:0] nidx;
    logic             rand_unused;

    assign cand        = rand_data[IDX_W-1:0];
    assign rand_unused = ^rand_data;
    assign accept      = (int'(cand) < CELLS) && (cand != safe) && !mine[cand];
    assign last_mine   = (int'(mines_placed) + 1 == MINES);

    // Adjacent-mine count of the scan cell; row/col are tracked alongside p so
    // no divider is needed, and out-of-grid neighbours are simply skipped.
    always_comb begin
        nbr  = 4'd0;
        nr   = 0;
        nc   = 0;
        nidx = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr   = int'(row) + dr;
                nc   = int'(col) + dc;
                nidx = IDX_W'(nr * COLS + nc);
                if ((dr != 0 || dc != 0) && nr >= 0 && nr < ROWS &&
                    nc >= 0 && nc < COLS && mine[nidx])
                    nbr = nbr + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mines_placed <= 8'd0;
            rd_mine      <= 1'b0;
            rd_count     <= 4'd0;
            mine         <= '0;
            for (int i = 0; i < MAP; i++) cnt[i] <= 4'd0;
            safe         <= '0;
            p            <= '0;
            row          <= '0;
            col          <= '0;
        end else begin
            rd_mine  <= (int'(rd_addr) < CELLS) && mine[rd_addr];
            rd_count <= (int'(rd_addr) < CELLS) ? cnt[rd_addr] : 4'd0;

            case (state)
                IDLE: begin
                    if (start) begin
                        safe  <= safe_cell;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    mine <= '0;
                    for (int i = 0; i < MAP; i++) cnt[i] <= 4'd0;
                    mines_placed <= 8'd0;
                    p     <= '0;
                    row   <= '0;
                    col   <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    if (MINES == 0) begin
                        state <= COUNT;
                    end else if (accept) begin
                        mine[cand]   <= 1'b1;
                        mines_placed <= mines_placed + 8'd1;
                        if (last_mine) state <= COUNT;
                    end
                end
                COUNT: begin
                    cnt[p] <= nbr;
                    if (int'(p) == CELLS - 1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        p <= p + 1'b1;
                        if (int'(col) == COLS - 1) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: directed LFSR byte sequences on several parameterisations,
// checked every cycle against a board/timeline model built from the placement rules.
module tb_mine_placer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [4:0] start_v;
    logic [5:0] safe_cell;
    logic [5:0] rd_addr;
    logic [7:0] rand_data;
    logic [4:0] mine_v;
    logic [4:0] busy_v;
    logic [4:0] done_v;
    logic [3:0] cnt_v    [5];
    logic [7:0] placed_v [5];

    mine_placer #(.ROWS(8), .COLS(8), .MINES(3)) u_a (
        .clock(clock), .reset(reset), .start(start_v[0]), .safe_cell(safe_cell),
        .rand_data(rand_data), .rd_addr(rd_addr), .rd_mine(mine_v[0]), .rd_count(cnt_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .mines_placed(placed_v[0]));
    mine_placer #(.ROWS(8), .COLS(8), .MINES(4)) u_b (
        .clock(clock), .reset(reset), .start(start_v[1]), .safe_cell(safe_cell),
        .rand_data(rand_data), .rd_addr(rd_addr), .rd_mine(mine_v[1]), .rd_count(cnt_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .mines_placed(placed_v[1]));
    mine_placer #(.ROWS(6), .COLS(6), .MINES(1)) u_c (
        .clock(clock), .reset(reset), .start(start_v[2]), .safe_cell(safe_cell),
        .rand_data(rand_data), .rd_addr(rd_addr), .rd_mine(mine_v[2]), .rd_count(cnt_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .mines_placed(placed_v[2]));
    mine_placer #(.ROWS(8), .COLS(8), .MINES(10)) u_d (
        .clock(clock), .reset(reset), .start(start_v[3]), .safe_cell(safe_cell),
        .rand_data(rand_data), .rd_addr(rd_addr), .rd_mine(mine_v[3]), .rd_count(cnt_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .mines_placed(placed_v[3]));
    mine_placer #(.ROWS(8), .COLS(8), .MINES(0)) u_e (
        .clock(clock), .reset(reset), .start(start_v[4]), .safe_cell(safe_cell),
        .rand_data(rand_data), .rd_addr(rd_addr), .rd_mine(mine_v[4]), .rd_count(cnt_v[4]),
        .busy(busy_v[4]), .done(done_v[4]), .mines_placed(placed_v[4]));

    int n_chk = 0;
    int n_fail = 0;
    int sel;
    int kcnt;
    bit active;
    bit rd_chk;
    logic [5:0] rd_smp;
    int prev_placed [5];

    // Model of the board under test and its expected timeline.
    int m_rows, m_cols, m_cells, m_mines, m_safe, m_D, m_L;
    bit m_mine [64];
    int m_cnt [64];
    int m_cum [$];
    logic [7:0] m_cq [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d, k=%0d, addr=%0d): got %0d, expected %0d",
                     name, sel, kcnt, rd_smp, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_mine[i] = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_build(input int rows, input int cols, input int mines, input int safe);
        int mask, placed, c, n, rr, cc;
        m_rows = rows; m_cols = cols; m_cells = rows * cols; m_mines = mines; m_safe = safe;
        model_clear();
        m_cum.delete();
        mask = 1;
        while (mask < m_cells) mask = mask * 2;
        mask = mask - 1;
        placed = 0;
        m_D = 0;
        foreach (m_cq[i]) begin
            c = int'(m_cq[i]) & mask;
            if (m_D == 0 && placed < mines && c < m_cells && c != safe && !m_mine[c]) begin
                m_mine[c] = 1'b1;
                placed++;
                if (placed == mines) m_D = i + 1;
            end
            m_cum.push_back(placed);
        end
        if (mines == 0) m_D = 1;
        m_L = (m_D == 0) ? 1000000 : 1 + m_D + m_cells;
        for (int r = 0; r < rows; r++) begin
            for (int q = 0; q < cols; q++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr; cc = q + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
                            n += int'(m_mine[rr * cols + cc]);
                    end
                m_cnt[r * cols + q] = n;
            end
        end
    endtask

    task automatic compare();
        int j, ep, a;
        if (active) begin
            if (kcnt == 0) begin
                ep = prev_placed[sel];
            end else begin
                j = kcnt - 1;
                if (m_D > 0 && j > m_D) j = m_D;
                if (j >= m_cum.size()) j = m_cum.size();
                ep = (j == 0) ? 0 : m_cum[j - 1];
            end
            chk("busy", int'(busy_v[sel]), int'(kcnt < m_L));
            chk("done", int'(done_v[sel]), int'(kcnt == m_L));
            chk("mines_placed", int'(placed_v[sel]), ep);
        end
        if (rd_chk) begin
            a = int'(rd_smp);
            chk("rd_mine", int'(mine_v[sel]), (a < m_cells) ? int'(m_mine[a]) : 0);
            chk("rd_count", int'(cnt_v[sel]), (a < m_cells) ? m_cnt[a] : 0);
            chk("idle_busy", int'(busy_v[sel]), 0);
            chk("idle_done", int'(done_v[sel]), 0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        rd_smp = rd_addr;
        if (active) kcnt++;
        @(negedge clock);
        compare();
    endtask

    // Launches a board on one instance; kcnt counts edges after the start edge.
    task automatic run(input int inst, input int rows, input int cols, input int mines,
                       input int safe, input int p1, input int p2, input bit hold,
                       input int stop_k);
        int e, last;
        model_build(rows, cols, mines, safe);
        sel = inst;
        safe_cell = 6'(safe);
        active = 1'b1;
        kcnt = -1;
        last = (stop_k >= 0) ? stop_k : m_L + 1;
        while (kcnt < last) begin
            e = kcnt + 1;
            start_v[inst] = (e == 0) || (e == p1) || (e == p2) || (hold && e >= m_L);
            rand_data = (e >= 2 && e - 2 < m_cq.size()) ? m_cq[e - 2] : 8'h00;
            tick();
        end
        active = 1'b0;
        if (stop_k < 0) prev_placed[inst] = mines;
    endtask

    task automatic sweep();
        rd_chk = 1'b1;
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            tick();
        end
        rd_chk = 1'b0;
    endtask

    initial begin
        start_v = '0; safe_cell = '0; rand_data = '0; rd_addr = '0;
        active = 1'b0; rd_chk = 1'b0; kcnt = -1; sel = 0; rd_smp = '0;
        for (int i = 0; i < 5; i++) prev_placed[i] = 0;
        m_cells = 64;
        model_clear();

        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        for (int i = 0; i < 5; i++) begin
            sel = i;
            chk("reset_busy", int'(busy_v[i]), 0);
            chk("reset_done", int'(done_v[i]), 0);
            chk("reset_placed", int'(placed_v[i]), 0);
            chk("reset_rd_mine", int'(mine_v[i]), 0);
            chk("reset_rd_count", int'(cnt_v[i]), 0);
        end
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        sel = 0;
        sweep();

        // Basic draw: duplicate 5 rejected, mines at 5, 18, 7.
        m_cq = '{8'h05, 8'h05, 8'h52, 8'hC7};
        run(0, 8, 8, 3, 0, -1, -1, 1'b0, -1);
        chk("model_L_basic", m_L, 69);
        chk("model_cum0", m_cum[0], 1);
        chk("model_cum1", m_cum[1], 1);
        chk("model_cum2", m_cum[2], 2);
        chk("model_cum3", m_cum[3], 3);
        chk("model_mine5", int'(m_mine[5]), 1);
        chk("model_mine18", int'(m_mine[18]), 1);
        chk("model_mine7", int'(m_mine[7]), 1);
        sweep();

        // Safe-cell exclusion: 0x09 and 0x49 both map to the safe cell.
        m_cq = '{8'h09, 8'h49, 8'h0A, 8'h0B, 8'h0C};
        run(0, 8, 8, 3, 9, -1, -1, 1'b0, -1);
        chk("model_safe9", int'(m_mine[9]), 0);
        chk("model_mine10", int'(m_mine[10]), 1);
        sweep();

        // Out-of-range rejection on a 6x6 grid.
        m_cq = '{8'h3F, 8'h24, 8'h23};
        run(2, 6, 6, 1, 0, -1, -1, 1'b0, -1);
        chk("model_D_6x6", m_D, 3);
        chk("model_mine35", int'(m_mine[35]), 1);
        chk("model_cnt28", m_cnt[28], 1);
        sweep();

        // Neighbour counts with mines at 1, 8, 9, 63.
        m_cq = '{8'h01, 8'h08, 8'h09, 8'h3F};
        run(1, 8, 8, 4, 0, -1, -1, 1'b0, -1);
        chk("model_cnt0", m_cnt[0], 3);
        chk("model_cnt10", m_cnt[10], 2);
        chk("model_cnt62", m_cnt[62], 1);
        chk("model_cnt54", m_cnt[54], 1);
        chk("model_cnt7", m_cnt[7], 0);
        chk("model_cnt9", m_cnt[9], 2);
        sweep();

        // MINES = 0: DRAW exits immediately.
        m_cq = '{8'h00};
        run(4, 8, 8, 0, 0, -1, -1, 1'b0, -1);
        chk("model_L_zero", m_L, 66);
        sweep();

        // Handshake: start pulses in DRAW and COUNT ignored, held start relaunches.
        m_cq = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
        run(3, 8, 8, 10, 0, 4, 30, 1'b1, -1);
        chk("model_L_hs", m_L, 75);
        m_cq = '{8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
        run(3, 8, 8, 10, 5, -1, -1, 1'b0, -1);
        sweep();

        // Asynchronous reset mid-DRAW with 4 mines placed.
        m_cq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        run(3, 8, 8, 10, 0, -1, -1, 1'b0, 7);
        #2 reset = 1'b0;
        #1;
        chk("midreset_busy", int'(busy_v[3]), 0);
        chk("midreset_done", int'(done_v[3]), 0);
        chk("midreset_placed", int'(placed_v[3]), 0);
        chk("midreset_rd_mine", int'(mine_v[3]), 0);
        chk("midreset_rd_count", int'(cnt_v[3]), 0);
        m_cells = 64;
        model_clear();
        for (int i = 0; i < 5; i++) prev_placed[i] = 0;
        sweep();
        #2 reset = 1'b1;
        sweep();
        m_cq = '{8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h2F, 8'h30, 8'h31};
        run(3, 8, 8, 10, 0, -1, -1, 1'b0, -1);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
